// File: rtl/os_acc_drain.sv
// Drain stage for one output-stationary PE row: snapshot all COLS accumulators, stream them column 0 first.
// Optional requantisation (arithmetic shift + int8 saturate) is enabled by defining DRAIN_REQUANT_EN.
module os_acc_drain #(
    parameter int COLS        = 4,
    parameter int ACC_WIDTH   = 32,
    parameter int SHIFT_WIDTH = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [COLS*ACC_WIDTH-1:0]  acc_in,
    input  logic                       cap_valid,
    output logic                       cap_ready,
    input  logic [SHIFT_WIDTH-1:0]     shift,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [ACC_WIDTH-1:0]       out_data,
    output logic [$clog2(COLS)-1:0]    out_col,
    output logic                       out_last,
    output logic                       overflow
);

    localparam int                IDX_W    = $clog2(COLS);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(COLS - 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_DRAIN = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [ACC_WIDTH-1:0]  r_snap [COLS];
    logic [IDX_W-1:0]      r_index;
    logic                  r_overflow;

    logic                  w_is_last;
    logic                  w_beat;
    logic                  w_cap_accept;
    logic [ACC_WIDTH-1:0]  w_word;
    logic [ACC_WIDTH-1:0]  w_drained;

    assign out_valid    = (r_state == S_DRAIN);
    assign w_is_last    = (r_index == LAST_IDX);
    assign w_beat       = out_valid & out_ready;
    assign w_word       = r_snap[r_index];

    // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_state_next = r_state;
        cap_ready    = 1'b0;
        case (r_state)
            S_IDLE: begin
                cap_ready = 1'b1;
                if (cap_valid) begin
                    w_state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // The final handshake frees the bank, so a new tile can land with no bubble.
                if (w_beat && w_is_last) begin
                    cap_ready    = 1'b1;
                    w_state_next = cap_valid ? S_DRAIN : S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    assign w_cap_accept = cap_valid & cap_ready;

    // NOTE: sequential state uses non-blocking assignments so every register updates from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: the snapshot bank is small and must read back as 0 after reset, so it is reset explicitly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < COLS; c++) begin
                r_snap[c] <= '0;
            end
        end else if (w_cap_accept) begin
            for (int c = 0; c < COLS; c++) begin
                r_snap[c] <= acc_in[c*ACC_WIDTH +: ACC_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_index <= '0;
        end else if (w_cap_accept) begin
            r_index <= '0;
        end else if (w_beat && !w_is_last) begin
            r_index <= r_index + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (cap_valid && !cap_ready) begin
            r_overflow <= 1'b1;
        end
    end

`ifdef DRAIN_REQUANT_EN
    localparam logic [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'(127);
    localparam logic [ACC_WIDTH-1:0] SAT_MIN = {{(ACC_WIDTH-8){1'b1}}, 8'h80};

    logic [SHIFT_WIDTH-1:0]      r_shift;
    logic signed [ACC_WIDTH-1:0] w_shifted;
    logic [ACC_WIDTH-8:0]        w_upper;
    logic                        w_fits;

    // The shift belongs to the tile, so it is latched alongside the snapshot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift <= '0;
        end else if (w_cap_accept) begin
            r_shift <= shift;
        end
    end

    assign w_shifted = $signed(w_word) >>> r_shift;
    assign w_upper   = w_shifted[ACC_WIDTH-1:7];
    assign w_fits    = (&w_upper) | ~(|w_upper);
    assign w_drained = w_fits ? $unsigned(w_shifted)
                              : (w_shifted[ACC_WIDTH-1] ? SAT_MIN : SAT_MAX);
`else
    logic w_unused_shift;

    assign w_unused_shift = ^shift;
    assign w_drained      = w_word;
`endif

    assign out_data = out_valid ? w_drained : '0;
    assign out_col  = out_valid ? r_index : '0;
    assign out_last = out_valid & w_is_last;
    assign overflow = r_overflow;

endmodule
